mmio_slot_router: RTL

- Single-outstanding memory-mapped I/O router between the CPU load/store path and four peripheral slots.
- Takes one CPU request, checks it against the MMIO region, and decodes address bits into a one-hot slot select.
- Forwards the request to the selected slot and waits for that slot's ack, with a timeout.
- Returns read data or an error to the CPU as a one-cycle response.

---
 rtl/mmio_slot_router.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mmio_slot_router.sv
// Single-outstanding MMIO router: region check, 2-to-4 slot decode, ack/timeout wait,
// and a one-cycle registered completion back to the CPU.
module mmio_slot_router #(
  parameter logic [31:0] BASE    = 32'h4000_0000,
  parameter int          SEL_LSB = 8,
  parameter int          TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_valid,
  output logic                 cpu_ready,
  input  logic [31:0]          cpu_addr,
  input  logic                 cpu_wr_ena,
  input  logic [31:0]          cpu_wdata,
  output logic                 cpu_rvalid,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_err,
  output logic [3:0]           slot_sel,
  output logic                 slot_wr_ena,
  output logic [SEL_LSB-1:0]   slot_addr,
  output logic [31:0]          slot_wdata,
  input  logic [127:0]         slot_rdata,
  input  logic [3:0]           slot_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         REG_LSB  = SEL_LSB + 2;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [3:0]           r_sel;
  logic                 r_wr;
  logic [SEL_LSB-1:0]   r_addr;
  logic [31:0]          r_wdata;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;
  logic                 r_err;

  state_t               w_state_nxt;
  logic [7:0]           w_cnt_nxt;
  logic [3:0]           w_sel_nxt;
  logic                 w_wr_nxt;
  logic [SEL_LSB-1:0]   w_addr_nxt;
  logic [31:0]          w_wdata_nxt;
  logic                 w_rvalid_nxt;
  logic [31:0]          w_rdata_nxt;
  logic                 w_err_nxt;
  logic                 w_in_region;
  logic                 w_ack;
  logic [31:0]          w_sel_data;

  assign cpu_ready   = (r_state == ST_IDLE);
  assign cpu_rvalid  = r_rvalid;
  assign cpu_rdata   = r_rdata;
  assign cpu_err     = r_err;
  assign slot_sel    = r_sel;
  assign slot_wr_ena = r_wr;
  assign slot_addr   = r_addr;
  assign slot_wdata  = r_wdata;

  assign w_in_region = (cpu_addr[31:REG_LSB] == BASE[31:REG_LSB]);
  // Only the selected slot's ack counts; others are masked off.
  assign w_ack       = |(slot_ack & r_sel);

  // Read-data mux driven by the one-hot select.
  always_comb begin
    w_sel_data = 32'd0;
    for (int k = 0; k < 4; k++) begin
      w_sel_data = w_sel_data | (slot_rdata[32*k +: 32] & {32{r_sel[k]}});
    end
  end

  // Next-state and next-output computation.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_wr_nxt     = r_wr;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rvalid_nxt = 1'b0;
    w_rdata_nxt  = 32'd0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_valid) begin
          if (w_in_region) begin
            w_sel_nxt   = 4'b0001 << cpu_addr[SEL_LSB+1:SEL_LSB];
            w_wr_nxt    = cpu_wr_ena;
            w_addr_nxt  = cpu_addr[SEL_LSB-1:0];
            w_wdata_nxt = cpu_wdata;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = ST_WAIT;
          end else begin
            w_rvalid_nxt = 1'b1;
            w_err_nxt    = 1'b1;
            w_state_nxt  = ST_RESP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Ack is checked first so it wins over the final timeout count.
        if (w_ack) begin
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = r_wr ? 32'd0 : w_sel_data;
          w_sel_nxt    = 4'd0;
          w_wr_nxt     = 1'b0;
          w_state_nxt  = ST_RESP;
        end else if (r_cnt == TMO_LAST) begin
          w_rvalid_nxt = 1'b1;
          w_err_nxt    = 1'b1;
          w_sel_nxt    = 4'd0;
          w_wr_nxt     = 1'b0;
          w_state_nxt  = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_RESP: begin
        w_sel_nxt   = 4'd0;
        w_wr_nxt    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_sel_nxt   = 4'd0;
        w_wr_nxt    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_sel    <= 4'd0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_wr     <= w_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rdata  <= w_rdata_nxt;
      r_err    <= w_err_nxt;
    end
  end

endmodule
